// File: rtl/alu_pkg.sv
// Shared opcode, field-position and FSM definitions for the ALU sequencer.
package alu_pkg;

  localparam logic [5:0] OP_AND  = 6'b000000;
  localparam logic [5:0] OP_OR   = 6'b000001;
  localparam logic [5:0] OP_NOT  = 6'b000010;
  localparam logic [5:0] OP_MUL  = 6'b000011;
  localparam logic [5:0] OP_DIV  = 6'b000100;
  localparam logic [5:0] OP_SRL  = 6'b000101;
  localparam logic [5:0] OP_SLL  = 6'b000110;
  localparam logic [5:0] OP_ADDI = 6'b001010;
  localparam logic [5:0] OP_SUBI = 6'b001011;

  // Instruction field bit positions
  localparam int F_OPC_HI = 31;
  localparam int F_OPC_LO = 26;
  localparam int F_A_HI   = 25;
  localparam int F_A_LO   = 21;
  localparam int F_B_HI   = 20;
  localparam int F_B_LO   = 16;
  localparam int F_C_HI   = 15;
  localparam int F_C_LO   = 11;
  localparam int F_SH_HI  = 10;
  localparam int F_SH_LO  = 6;
  localparam int F_IMM_HI = 15;

  localparam logic [31:0] DIVZ_RESULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DIV_WAIT,
    ST_WB
  } state_e;

  function automatic logic is_itype(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI);
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/alu_div_serial.sv
// Unsigned restoring divider, one quotient bit per clock, start/done handshake.
module alu_div_serial
  import alu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic              done_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o
);

  localparam int CNT_W = $clog2(DIV_CYCLES);

  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
  logic [DATA_W-1:0] src_rem, src_quo, src_dvs;
  logic [DATA_W-1:0] rem_d, quo_d;
  logic [DATA_W:0]   trial;

  // The start cycle already performs the first step from the fresh operands.
  always_comb begin
    src_rem = start_i ? '0 : rem_q;
    src_quo = start_i ? dividend_i : quo_q;
    src_dvs = start_i ? divisor_i : dvs_q;
    trial   = {src_rem, src_quo[DATA_W-1]};
    if (trial >= {1'b0, src_dvs}) begin
      rem_d = trial[DATA_W-1:0] - src_dvs;
      quo_d = {src_quo[DATA_W-2:0], 1'b1};
    end else begin
      rem_d = trial[DATA_W-1:0];
      quo_d = {src_quo[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= CNT_W'(DIV_CYCLES - 1);
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= divisor_i;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
        rem_q <= rem_d;
        quo_q <= quo_d;
      end
    end
  end

  assign done_o      = busy_q && (cnt_q == '0);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller: accepts an instruction, executes it on the ALU or
// serial divider, and writes the result into the architectural register file.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic              done_valid,
  output logic [DATA_W-1:0] done_data,
  output logic [REG_AW-1:0] done_addr,
  output logic              err_illegal,
  output logic              err_divz,
  output logic              busy,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e            state_q, state_d;
  logic [31:0]       instr_q;
  logic [DATA_W-1:0] result_q;
  logic              illegal_q, divz_q;
  logic [DATA_W-1:0] rf_q [2**REG_AW];

  logic [5:0]        opcode;
  logic              itype;
  logic [REG_AW-1:0] rd, rs_a, rt_a;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] rs_val, rt_val, imm_sx, alu_res;
  logic              alu_ok, is_div, rt_zero, div_start, div_done;
  logic [DATA_W-1:0] div_quo, div_rem_unused;

  assign opcode = instr_q[F_OPC_HI:F_OPC_LO];
  assign itype  = is_itype(opcode);
  assign rd     = itype ? instr_q[F_B_HI:F_B_LO] : instr_q[F_A_HI:F_A_LO];
  assign rs_a   = itype ? instr_q[F_A_HI:F_A_LO] : instr_q[F_B_HI:F_B_LO];
  assign rt_a   = instr_q[F_C_HI:F_C_LO];
  assign shamt  = instr_q[F_SH_HI:F_SH_LO];
  assign imm_sx = sext16(instr_q[F_IMM_HI:0]);
  assign rs_val = rf_q[rs_a];
  assign rt_val = rf_q[rt_a];

  assign is_div    = (opcode == OP_DIV);
  assign rt_zero   = (rt_val == '0);
  assign div_start = (state_q == ST_EXEC) && is_div && !rt_zero;

  always_comb begin
    alu_res = '0;
    alu_ok  = 1'b1;
    case (opcode)
      OP_AND:  alu_res = rs_val & rt_val;
      OP_OR:   alu_res = rs_val | rt_val;
      OP_NOT:  alu_res = ~rs_val;
      OP_MUL:  alu_res = rs_val * rt_val;
      OP_DIV:  alu_res = '0;
      OP_SRL:  alu_res = rs_val >> shamt;
      OP_SLL:  alu_res = rs_val << shamt;
      OP_ADDI: alu_res = rs_val + imm_sx;
      OP_SUBI: alu_res = rs_val - imm_sx;
      default: alu_ok  = 1'b0;
    endcase
  end

  alu_div_serial #(
    .DATA_W     (DATA_W),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .dividend_i  (rs_val),
    .divisor_i   (rt_val),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (instr_valid) state_d = ST_EXEC;
      ST_EXEC:     state_d = div_start ? ST_DIV_WAIT : ST_WB;
      ST_DIV_WAIT: if (div_done) state_d = ST_WB;
      ST_WB:       state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state_q == ST_IDLE);
    busy        = (state_q != ST_IDLE);
    done_valid  = (state_q == ST_WB);
    done_data   = done_valid ? result_q : '0;
    done_addr   = done_valid ? rd : '0;
    err_illegal = done_valid && illegal_q;
    err_divz    = done_valid && divz_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q   <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
      divz_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (instr_valid) instr_q <= instr;
        ST_EXEC: begin
          illegal_q <= !alu_ok;
          divz_q    <= alu_ok && is_div && rt_zero;
          if (!alu_ok)             result_q <= '0;
          else if (is_div && rt_zero) result_q <= DIVZ_RESULT;
          else                     result_q <= alu_res;
        end
        ST_DIV_WAIT: if (div_done) result_q <= div_quo;
        default: ;
      endcase
    end
  end

  // r0 is never written, so it reads as zero without a special read path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**REG_AW; i++) rf_q[i] <= '0;
    end else if ((state_q == ST_WB) && !illegal_q && (rd != '0)) begin
      rf_q[rd] <= result_q;
    end
  end

  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed steps plus randomized ops
// compared against an arithmetic reference model of the register file.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        done_valid;
  logic [31:0] done_data;
  logic [4:0]  done_addr;
  logic        err_illegal, err_divz, busy;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] mrf [32];

  alu_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .done_valid  (done_valid),
    .done_data   (done_data),
    .done_addr   (done_addr),
    .err_illegal (err_illegal),
    .err_divz    (err_divz),
    .busy        (busy),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [5:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] sh);
    return {op, rd, rs, rt, sh, 6'b0};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rd, input logic [15:0] imm);
    return {op, rs, rd, imm};
  endfunction

  // Reference model: the architectural effect of one instruction.
  task automatic model(input logic [31:0] ins, output logic [31:0] res, output logic [4:0] rd,
                       output logic ill, output logic dz, output int lat);
    logic [5:0]  op;
    logic [31:0] a, b, imm;
    logic [63:0] prod;
    logic [4:0]  sh;
    bit          itype;
    op    = ins[31:26];
    itype = (op == 6'd10) || (op == 6'd11);
    rd    = itype ? ins[20:16] : ins[25:21];
    a     = mrf[itype ? ins[25:21] : ins[20:16]];
    b     = mrf[ins[15:11]];
    sh    = ins[10:6];
    imm   = {{16{ins[15]}}, ins[15:0]};
    res = 32'd0; ill = 1'b0; dz = 1'b0; lat = 2;
    case (op)
      6'd0:  res = a & b;
      6'd1:  res = a | b;
      6'd2:  res = ~a;
      6'd3:  begin prod = a * b; res = prod[31:0]; end
      6'd4:  if (b == 0) begin res = 32'hFFFF_FFFF; dz = 1'b1; end
             else begin res = a / b; lat = 34; end
      6'd5:  res = a >> sh;
      6'd6:  res = a << sh;
      6'd10: res = a + imm;
      6'd11: res = a - imm;
      default: ill = 1'b1;
    endcase
  endtask

  task automatic run_instr(input logic [31:0] ins, input string tag);
    logic [31:0] e_res;
    logic [4:0]  e_rd;
    logic        e_ill, e_dz;
    int          e_lat, cyc;
    bit          got, side_ok;
    model(ins, e_res, e_rd, e_ill, e_dz, e_lat);
    @(negedge clk);
    instr = ins;
    instr_valid = 1'b1;
    chk({tag, ".ready"}, {31'd0, instr_ready}, 32'd1);
    @(posedge clk);
    // Garbage stays offered while busy and must be ignored.
    #1 instr = $urandom();
    cyc = 0; got = 0; side_ok = 1;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done_valid) got = 1;
      if (!busy || instr_ready) side_ok = 0;
    end
    instr_valid = 1'b0;
    chk({tag, ".latency"}, got ? 32'(cyc) : 32'hFFFF_FFFF, 32'(e_lat));
    chk({tag, ".busy_held"}, {31'd0, side_ok}, 32'd1);
    chk({tag, ".data"}, done_data, e_ill ? 32'd0 : e_res);
    chk({tag, ".addr"}, {27'd0, done_addr}, {27'd0, e_rd});
    chk({tag, ".err_illegal"}, {31'd0, err_illegal}, {31'd0, e_ill});
    chk({tag, ".err_divz"}, {31'd0, err_divz}, {31'd0, e_dz});
    if (!e_ill && e_rd != 0) mrf[e_rd] = e_res;
    @(negedge clk);
    dbg_addr = e_rd;
    #1;
    chk({tag, ".pulse_end"}, {31'd0, done_valid}, 32'd0);
    chk({tag, ".dbg_rd"}, dbg_data, mrf[e_rd]);
  endtask

  initial begin
    logic [5:0] ops [11];
    int         pulses;
    ops = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd10, 6'd11, 6'd7, 6'd63};
    for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    rst = 1'b1; instr_valid = 1'b0; instr = 32'd0; dbg_addr = 5'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.ready", {31'd0, instr_ready}, 32'd1);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done_valid", {31'd0, done_valid}, 32'd0);
    chk("rst.done_data", done_data, 32'd0);
    chk("rst.done_addr", {27'd0, done_addr}, 32'd0);
    chk("rst.errs", {30'd0, err_illegal, err_divz}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_instr(i_type(6'd10, 5'd0, 5'd1, 16'h00F0), "addi_r1");
    run_instr(i_type(6'd10, 5'd0, 5'd2, 16'h000F), "addi_r2");
    run_instr(r_type(6'd0, 5'd3, 5'd1, 5'd2, 5'd0), "and");
    run_instr(r_type(6'd1, 5'd4, 5'd1, 5'd2, 5'd0), "or");
    run_instr(r_type(6'd6, 5'd5, 5'd2, 5'd0, 5'd4), "sll");
    run_instr(r_type(6'd5, 5'd6, 5'd1, 5'd0, 5'd31), "srl");
    run_instr(r_type(6'd2, 5'd7, 5'd2, 5'd0, 5'd0), "not");
    run_instr(i_type(6'd11, 5'd0, 5'd8, 16'h0001), "subi_wrap");
    run_instr(i_type(6'd10, 5'd0, 5'd10, 16'h8000), "addi_sext");
    run_instr(i_type(6'd10, 5'd0, 5'd11, 16'd100), "addi_r11");
    run_instr(i_type(6'd10, 5'd0, 5'd12, 16'd7), "addi_r12");
    run_instr(r_type(6'd4, 5'd9, 5'd11, 5'd12, 5'd0), "div");
    run_instr(r_type(6'd4, 5'd13, 5'd11, 5'd0, 5'd0), "divz");
    run_instr(r_type(6'd3, 5'd14, 5'd11, 5'd12, 5'd0), "mul");
    run_instr(r_type(6'd63, 5'd4, 5'd1, 5'd2, 5'd0), "illegal");
    run_instr(i_type(6'd10, 5'd0, 5'd0, 16'h0005), "wr_r0");

    chk("known.r3", mrf[3], 32'h0000_0000);
    chk("known.r4", mrf[4], 32'h0000_00FF);
    chk("known.r7", mrf[7], 32'hFFFF_FFF0);
    chk("known.r9", mrf[9], 32'd14);
    chk("known.r10", mrf[10], 32'hFFFF_8000);

    for (int i = 0; i < 40; i++) begin
      logic [5:0]  op;
      logic [31:0] ins;
      op = ops[$urandom_range(0, 10)];
      if (op == 6'd10 || op == 6'd11)
        ins = i_type(op, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 16'($urandom()));
      else
        ins = r_type(op, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                     5'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
      run_instr(ins, "rand");
    end

    // Reset in the middle of a divide.
    @(negedge clk);
    instr = r_type(6'd4, 5'd15, 5'd11, 5'd12, 5'd0);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst.ready", {31'd0, instr_ready}, 32'd1);
    chk("midrst.busy", {31'd0, busy}, 32'd0);
    chk("midrst.done_valid", {31'd0, done_valid}, 32'd0);
    chk("midrst.done_data", done_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    for (int a = 0; a < 32; a++) begin
      dbg_addr = 5'(a);
      #1 chk("midrst.dbg", dbg_data, 32'd0);
    end
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_valid) pulses++;
    end
    chk("midrst.no_done", 32'(pulses), 32'd0);
    run_instr(i_type(6'd10, 5'd0, 5'd1, 16'h1234), "post_rst_addi");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle controller that sequences the team's R-type/I-type ALU datapath.
- Accepts one 32-bit instruction per valid/ready handshake, reads operands from an internal register file, and executes the op (one cycle, or iterative for divide).
- Writes the result back and reports completion and errors to the fetch stage.
- Sits between instruction fetch and the ALU; it is the only writer of the architectural register file.

Parameters:
- DATA_W, 32, operand/result width. Only 32 is supported.
- REG_AW, 5, register address width, giving 2**REG_AW registers.
- DIV_CYCLES, 32, iterations of the serial divider. Must equal DATA_W.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept an instruction.
- instr  in  32  instruction word.
- done_valid  out  1  one-cycle pulse: instruction retired.
- done_data  out  32  result written (0 if illegal).
- done_addr  out  5  destination register.
- err_illegal  out  1  pulse with done_valid: opcode unsupported.
- err_divz  out  1  pulse with done_valid: divide by zero.
- busy  out  1  FSM not IDLE.
- dbg_addr  in  5  debug read address.
- dbg_data  out  32  combinational register-file read.

Behaviour:
- Encoding:
  - opcode = instr[31:26].
  - R-type: rd=[25:21], rs=[20:16], rt=[15:11], shamt=[10:6].
  - I-type (opcode 001010, 001011): rs=[25:21], rd=[20:16], imm=[15:0], sign-extended to 32 bits.
- Ops:
  - 000000 AND: rs&rt
  - 000001 OR: rs|rt
  - 000010 NOT: ~rs
  - 000011 MUL: low 32 bits of unsigned rs*rt
  - 000100 DIV: unsigned rs/rt
  - 000101 SRL: rs>>shamt (logical)
  - 000110 SLL: rs<<shamt
  - 001010 ADDI: rs+imm (mod 2^32)
  - 001011 SUBI: rs-imm (mod 2^32)
  - Any other opcode is illegal.
- Register file: 32x32. r0 reads as 0; writes to r0 are discarded, but done_* still reports addr 0 and the computed data.
- FSM states: IDLE, EXEC, DIV_WAIT, WB.
  - IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr and go to EXEC.
  - EXEC: read operands. For a non-DIV op, compute into the result register and go to WB. For DIV with rt==0, set result=32'hFFFFFFFF and a divz flag, then go to WB. For DIV with rt!=0, start the divider and go to DIV_WAIT.
  - DIV_WAIT: stay until the divider reports done (exactly DIV_CYCLES cycles after start), latch the quotient, go to WB.
  - WB: write the register file (unless illegal or rd==0), pulse done_valid plus the error flags, go to IDLE.
- Latency, counted from the accept edge = cycle 0:
  - non-DIV: done_valid high in cycle 2.
  - DIV: done_valid high in cycle 2+DIV_CYCLES.
  - Throughput: one instruction per 3 cycles at best. instr_ready stays low outside IDLE.
- Illegal opcode: no register write, done_data=0, err_illegal=1 with done_valid.
- Divide by zero: writes 32'hFFFFFFFF, err_divz=1.
- Read-during-write: a debug read or operand read of the WB address in the same cycle returns the old value; the new value is visible the next cycle. This is safe because no operand read happens in WB.
- instr is ignored when instr_ready=0. instr_valid need not be held after accept.
- Reset, asynchronous at any time including mid-divide:
  - FSM goes to IDLE and the divider is aborted.
  - All registers clear to 0.
  - Outputs: instr_ready=1, busy=0, done_valid=0, err_*=0, done_data=0, done_addr=0.
  - No partial write-back occurs.

Decomposition:
- Package alu_pkg:
  - opcode localparams (OP_AND … OP_SUBI).
  - FSM state enum.
  - field-slice positions.
  - DIVZ_RESULT constant = 32'hFFFFFFFF.
- Sub-module alu_div_serial:
  - Unsigned restoring divider with start/done handshake and quotient/remainder outputs.
  - Async active-high reset on the same clk/rst.
- The combinational single-cycle op mux stays inside alu_sequencer.

Test Plan:
- Reset, then preload via a sequence of ADDI ops: r1=0x0000_00F0, r2=0x0000_000F (ADDI from r0). Then AND r3,r1,r2 -> done_data=0, done_addr=3, done_valid in cycle 2 after accept.
- OR r4,r1,r2 -> 0x0000_00FF. SLL r5,r2,shamt=4 -> 0x0000_00F0. SRL r6,r1,shamt=31 -> 0. NOT r7,r2 -> 0xFFFF_FFF0.
- SUBI r8=r0-1 -> 0xFFFF_FFFF (wrap). ADDI with imm=0x8000 -> sign-extended 0xFFFF_8000.
- DIV r9 = 100/7 -> 14, done_valid exactly 34 cycles after accept, busy high throughout. DIV by r0 -> 0xFFFF_FFFF with err_divz=1.
- Opcode 111111 -> err_illegal=1, done_data=0, dbg read of rd unchanged. Write to r0 -> dbg_data(0)=0.
- Assert rst mid-DIV (cycle 10) -> instr_ready=1 and busy=0 immediately, no done_valid, all dbg reads 0. A new ADDI is then accepted normally.
